// File: rtl/game_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared game definitions. Holds the game FSM state encoding
//               seen on state_in, the setup-register addresses read at the
//               start of a game, and the data code a responder returns to
//               signal a failed read.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Encoding of the top-level game FSM state.
    typedef enum logic [2:0] {
        MENU      = 3'd0,
        PLAY      = 3'd1,
        PAUSE     = 3'd2,
        WIN       = 3'd3,
        LOST      = 3'd4,
        GAME_OVER = 3'd5
    } game_state_e;

    // Number of named setup words held by the reader.
    localparam int C_NUM_SETUP_WORDS = 7;

    // Setup-register word addresses. Registers are 16 bits wide on a byte
    // addressed bus, so consecutive words are two addresses apart.
    localparam logic [7:0] C_ADR_ROW_COLUMN_NUMBER = 8'h00;
    localparam logic [7:0] C_ADR_MINE_NUM          = 8'h02;
    localparam logic [7:0] C_ADR_TIMER_SECONDS     = 8'h04;
    localparam logic [7:0] C_ADR_FIELD_SIZE        = 8'h06;
    localparam logic [7:0] C_ADR_BOARD_SIZE        = 8'h08;
    localparam logic [7:0] C_ADR_BOARD_XPOS        = 8'h0A;
    localparam logic [7:0] C_ADR_BOARD_YPOS        = 8'h0C;

    // Data value a responder returns instead of a real setup word on failure.
    localparam logic [15:0] C_DATA_ERROR = 16'hDEAD;

    // Bus address of setup word 'idx'.
    function automatic logic [7:0] setup_word_addr(input logic [2:0] idx);
        logic [7:0] adr;
        case (idx)
            3'd0:    adr = C_ADR_ROW_COLUMN_NUMBER;
            3'd1:    adr = C_ADR_MINE_NUM;
            3'd2:    adr = C_ADR_TIMER_SECONDS;
            3'd3:    adr = C_ADR_FIELD_SIZE;
            3'd4:    adr = C_ADR_BOARD_SIZE;
            3'd5:    adr = C_ADR_BOARD_XPOS;
            3'd6:    adr = C_ADR_BOARD_YPOS;
            default: adr = 8'h00;
        endcase
        return adr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wishbone_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wishbone_if
// Description : Minimal pipelined Wishbone read channel used to fetch setup
//               registers.
//               master: drives stb_o, we_o, adr_o[7:0]
//                       samples stall_i, ack_i, dat_i[15:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface wishbone_if;
    logic        stb_o;
    logic        we_o;
    logic [7:0]  adr_o;
    logic        stall_i;
    logic        ack_i;
    logic [15:0] dat_i;

    modport master (
        output stb_o,
        output we_o,
        output adr_o,
        input  stall_i,
        input  ack_i,
        input  dat_i
    );

    modport slave (
        input  stb_o,
        input  we_o,
        input  adr_o,
        output stall_i,
        output ack_i,
        output dat_i
    );
endinterface
`default_nettype wire

// File: rtl/game_cfg_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : game_cfg_reader
// Description : Fetches the game setup words over a Wishbone read channel
//               each time the game goes from MENU to PLAY, one word at a
//               time with a per-word timeout, and holds the results.
// Ports       : clk, rst            - clock, async active-high reset
//               state_in[2:0]       - game FSM state (game_pkg encoding)
//               cfg_wb              - Wishbone master (read only)
//               row_column_number,
//               mine_num, timer_seconds, field_size, board_size,
//               board_xpos, board_ypos [15:0] - latched setup words
//               cfg_valid           - complete error-free config held
//               cfg_error           - last fetch aborted (timeout / DEAD)
//               busy                - fetch in progress
// Revision    : 1.0 - initial release
// ============================================================================
module game_cfg_reader
    import game_pkg::*;
#(
    parameter int NUM_REGS       = 7,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  state_in,
    wishbone_if.master  cfg_wb,
    output logic [15:0] row_column_number,
    output logic [15:0] mine_num,
    output logic [15:0] timer_seconds,
    output logic [15:0] field_size,
    output logic [15:0] board_size,
    output logic [15:0] board_xpos,
    output logic [15:0] board_ypos,
    output logic        cfg_valid,
    output logic        cfg_error,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_DONE     = 3'd3,
        S_ERR      = 3'd4
    } fetch_state_e;

    localparam logic [2:0] C_LAST_IDX = 3'(NUM_REGS - 1);
    localparam logic [4:0] C_TMO_LAST = 5'(TIMEOUT_CYCLES - 1);

    fetch_state_e state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    logic [4:0]   tmo_q, tmo_d;
    logic [2:0]   prev_state_q, prev_state_d;
    logic [15:0]  word_q [C_NUM_SETUP_WORDS];
    logic [15:0]  word_d [C_NUM_SETUP_WORDS];
    logic         cfg_valid_q, cfg_valid_d;
    logic         cfg_error_q, cfg_error_d;

    logic w_start;
    logic w_ack;
    logic w_bad_data;
    logic w_expired;

    // Only a genuine MENU->PLAY transition starts a fetch; a start seen
    // while the sequencer is anywhere but IDLE is dropped.
    assign w_start    = (state_in == PLAY) && (prev_state_q == MENU) &&
                        (state_q == S_IDLE);
    assign w_ack      = (state_q == S_WAIT_ACK) && cfg_wb.ack_i;
    assign w_bad_data = (cfg_wb.dat_i == C_DATA_ERROR);
    // Last counted cycle of the window that opened on entry to REQ.
    assign w_expired  = (tmo_q == C_TMO_LAST);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tmo_d        = tmo_q;
        prev_state_d = state_in;
        word_d       = word_q;
        cfg_valid_d  = cfg_valid_q;
        cfg_error_d  = cfg_error_q;

        if (state_in == MENU) begin
            cfg_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    state_d     = S_REQ;
                    idx_d       = 3'd0;
                    tmo_d       = 5'd0;
                    cfg_valid_d = 1'b0;
                    cfg_error_d = 1'b0;
                end
            end

            S_REQ: begin
                // The window keeps counting while stalled; a request that
                // is only accepted on the final cycle has no time left for
                // its acknowledge, so it is aborted as well.
                if (w_expired) begin
                    state_d     = S_ERR;
                    cfg_error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 5'd1;
                    if (!cfg_wb.stall_i) begin
                        state_d = S_WAIT_ACK;
                    end
                end
            end

            S_WAIT_ACK: begin
                if (w_ack) begin
                    if (w_bad_data) begin
                        state_d     = S_ERR;
                        cfg_error_d = 1'b1;
                    end else begin
                        for (int i = 0; i < C_NUM_SETUP_WORDS; i++) begin
                            if (idx_q == 3'(i)) begin
                                word_d[i] = cfg_wb.dat_i;
                            end
                        end
                        if (idx_q == C_LAST_IDX) begin
                            state_d     = S_DONE;
                            cfg_valid_d = 1'b1;
                        end else begin
                            state_d = S_REQ;
                            idx_d   = idx_q + 3'd1;
                            tmo_d   = 5'd0;
                        end
                    end
                end else if (w_expired) begin
                    state_d     = S_ERR;
                    cfg_error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 5'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_ERR: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= 3'd0;
            tmo_q        <= 5'd0;
            prev_state_q <= MENU;
            cfg_valid_q  <= 1'b0;
            cfg_error_q  <= 1'b0;
            for (int i = 0; i < C_NUM_SETUP_WORDS; i++) begin
                word_q[i] <= 16'h0000;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tmo_q        <= tmo_d;
            prev_state_q <= prev_state_d;
            cfg_valid_q  <= cfg_valid_d;
            cfg_error_q  <= cfg_error_d;
            word_q       <= word_d;
        end
    end

    assign cfg_wb.stb_o = (state_q == S_REQ);
    assign cfg_wb.we_o  = 1'b0;
    assign cfg_wb.adr_o = (state_q == S_REQ) ? setup_word_addr(idx_q) : 8'h00;

    assign row_column_number = word_q[0];
    assign mine_num          = word_q[1];
    assign timer_seconds     = word_q[2];
    assign field_size        = word_q[3];
    assign board_size        = word_q[4];
    assign board_xpos        = word_q[5];
    assign board_ypos        = word_q[6];

    assign cfg_valid = cfg_valid_q;
    assign cfg_error = cfg_error_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_game_cfg_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_game_cfg_reader
// Description : Self-checking bench for game_cfg_reader. A behavioural
//               responder serves setup words with per-word stall / fault
//               plans; a reference model predicts requested addresses and
//               the configuration held after each fetch, and a monitor
//               compares whenever a fetch ends.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_cfg_reader;
    import game_pkg::*;

    localparam int N    = 7;
    localparam int TMO  = 16;
    localparam int LATE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  state_in;
    logic [15:0] row_column_number, mine_num, timer_seconds, field_size;
    logic [15:0] board_size, board_xpos, board_ypos;
    logic        cfg_valid, cfg_error, busy;

    wishbone_if wb ();

    game_cfg_reader #(.NUM_REGS(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .state_in          (state_in),
        .cfg_wb            (wb),
        .row_column_number (row_column_number),
        .mine_num          (mine_num),
        .timer_seconds     (timer_seconds),
        .field_size        (field_size),
        .board_size        (board_size),
        .board_xpos        (board_xpos),
        .board_ypos        (board_ypos),
        .cfg_valid         (cfg_valid),
        .cfg_error         (cfg_error),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0][15:0] w;
        logic               valid;
        logic               err;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] adr_q [$];
    int         errors = 0;
    int         checks = 0;

    // Responder plan: 0 = ack with mem, 1 = never ack, 2 = ack with DEAD,
    // 3 = ack LATE cycles after the normal slot.
    logic [15:0] mem       [N];
    int          stall_cnt [N];
    int          ack_mode  [N];

    logic [N-1:0][15:0] model_w;
    bit          abandon = 1'b0;
    int          accepts = 0;
    int          word0_run = 0;
    bit          adr_unstable = 1'b0;

    // Responder private state
    int          rsp_stall_left = 0, rsp_run = 0, rsp_late = 0, rsp_pend_w = 0, rsp_w = 0;
    bit          rsp_in_req = 1'b0, rsp_pend = 1'b0;
    logic [7:0]  rsp_req_adr = 8'h00, rsp_exp_adr;

    bit          mon_prev_busy = 1'b0;
    exp_t        mon_e;

    function automatic logic [N-1:0][15:0] dut_words();
        return {board_ypos, board_xpos, board_size, field_size,
                timer_seconds, mine_num, row_column_number};
    endfunction

    task automatic chk(input string name, input logic [111:0] act, input logic [111:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- responder ----------------
    initial begin
        wb.stall_i = 1'b0;
        wb.ack_i   = 1'b0;
        wb.dat_i   = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            wb.ack_i   = 1'b0;
            wb.dat_i   = 16'h0000;
            wb.stall_i = 1'b0;
            if (rsp_late > 0) begin
                rsp_late--;
                if (rsp_late == 0) begin
                    wb.ack_i = 1'b1;
                    wb.dat_i = 16'h5A5A;
                end
            end
            if (rsp_pend) begin
                rsp_pend = 1'b0;
                case (ack_mode[rsp_pend_w])
                    0: begin wb.ack_i = 1'b1; wb.dat_i = mem[rsp_pend_w]; end
                    2: begin wb.ack_i = 1'b1; wb.dat_i = C_DATA_ERROR; end
                    3: rsp_late = LATE;
                    default: ;
                endcase
            end
            if (wb.stb_o && !rst) begin
                rsp_w = int'(wb.adr_o[3:1]);
                if (rsp_w >= N) rsp_w = 0;
                if (!rsp_in_req) begin
                    rsp_in_req     = 1'b1;
                    rsp_run        = 0;
                    rsp_req_adr    = wb.adr_o;
                    rsp_stall_left = stall_cnt[rsp_w];
                end
                rsp_run++;
                if (wb.adr_o != rsp_req_adr) adr_unstable = 1'b1;
                if (rsp_stall_left > 0) begin
                    wb.stall_i = 1'b1;
                    rsp_stall_left--;
                end else begin
                    rsp_in_req = 1'b0;
                    rsp_pend   = 1'b1;
                    rsp_pend_w = rsp_w;
                    if (rsp_w == 0) word0_run = rsp_run;
                    accepts++;
                    if (adr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL bus_request: actual adr=%0h required no request", wb.adr_o);
                    end else begin
                        rsp_exp_adr = adr_q.pop_front();
                        chk("bus_adr", 112'(wb.adr_o), 112'(rsp_exp_adr));
                    end
                    chk("bus_we", 112'(wb.we_o), 112'(0));
                end
            end else begin
                rsp_in_req = 1'b0;
            end
        end
    end

    // ---------------- completion monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (mon_prev_busy && !busy) begin
                if (abandon) begin
                    abandon = 1'b0;
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fetch_end: actual unexpected completion required none");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("cfg_words", 112'(dut_words()), 112'(mon_e.w));
                    chk("cfg_valid", 112'(cfg_valid), 112'(mon_e.valid));
                    chk("cfg_error", 112'(cfg_error), 112'(mon_e.err));
                end
            end
            mon_prev_busy = busy;
        end
    end

    // ---------------- reference model ----------------
    task automatic predict();
        exp_t e;
        e.err = 1'b0;
        for (int i = 0; i < N; i++) begin
            adr_q.push_back(8'(2 * i));
            if (ack_mode[i] != 0) begin
                e.err = 1'b1;
                break;
            end
            model_w[i] = mem[i];
        end
        e.valid = !e.err;
        e.w     = model_w;
        exp_q.push_back(e);
    endtask

    // Edges from the start edge until cfg_valid / cfg_error becomes visible.
    function automatic int exp_latency();
        int t = 0;
        for (int i = 0; i < N; i++) begin
            if (ack_mode[i] == 1) return t + TMO;
            t += 2 + stall_cnt[i];
            if (ack_mode[i] != 0) return t;
        end
        return t;
    endfunction

    task automatic clear_plan();
        for (int i = 0; i < N; i++) begin
            stall_cnt[i] = 0;
            ack_mode[i]  = 0;
        end
    endtask

    task automatic rand_mem();
        logic [15:0] v;
        for (int i = 0; i < N; i++) begin
            v = 16'($urandom);
            if (v == C_DATA_ERROR) v = 16'h0000;
            mem[i] = v;
        end
    endtask

    task automatic go_menu();
        @(negedge clk);
        state_in = MENU;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_fetch(input bit mid_pause, output int lat);
        int n;
        go_menu();
        predict();
        @(negedge clk);
        state_in = PLAY;
        @(posedge clk);
        #1;
        n = 0;
        while (!(cfg_valid || cfg_error) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (mid_pause && n == 3) state_in = PAUSE;
        end
        lat = n;
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: actual no completion in %0d cycles required completion", n);
        end
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_words"}, 112'(dut_words()), 112'(0));
        chk({tag, "_valid"}, 112'(cfg_valid), 112'(0));
        chk({tag, "_error"}, 112'(cfg_error), 112'(0));
        chk({tag, "_busy"},  112'(busy), 112'(0));
        chk({tag, "_stb"},   112'(wb.stb_o), 112'(0));
        chk({tag, "_adr"},   112'(wb.adr_o), 112'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, n, stb_cnt, acc0, fault, fw;
        rst      = 1'b1;
        state_in = MENU;
        model_w  = '0;
        clear_plan();
        for (int i = 0; i < N; i++) mem[i] = 16'(16'h0008 + 2 * i);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Directed read of 0x0008, 0x000A, ... with 1-cycle acks.
        run_fetch(1'b0, lat);
        chk("latency_basic", 112'(lat), 112'(14));

        // Three stall cycles on the first request.
        adr_unstable = 1'b0;
        stall_cnt[0] = 3;
        rand_mem();
        run_fetch(1'b0, lat);
        chk("stall_stb_cycles", 112'(word0_run), 112'(4));
        chk("stall_adr_stable", 112'(adr_unstable), 112'(0));
        chk("latency_stall", 112'(lat), 112'(17));
        clear_plan();

        // Word 2 never acknowledged.
        rand_mem();
        ack_mode[2] = 1;
        run_fetch(1'b0, lat);
        chk("latency_noack", 112'(lat), 112'(2 * 2 + TMO));
        clear_plan();

        // Valid fetch, then DEAD on word 4.
        rand_mem();
        run_fetch(1'b0, lat);
        rand_mem();
        ack_mode[4] = 2;
        run_fetch(1'b0, lat);
        chk("latency_dead", 112'(lat), 112'(10));
        clear_plan();

        // PLAY->PAUSE->PLAY must not refetch; MENU drops cfg_valid.
        rand_mem();
        run_fetch(1'b0, lat);
        @(negedge clk);
        state_in = PAUSE;
        repeat (3) @(negedge clk);
        state_in = PLAY;
        stb_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb.stb_o) stb_cnt++;
        end
        chk("pause_no_stb", 112'(stb_cnt), 112'(0));
        chk("pause_valid_hold", 112'(cfg_valid), 112'(1));
        state_in = MENU;
        repeat (2) @(negedge clk);
        chk("menu_valid_clear", 112'(cfg_valid), 112'(0));

        // Reset while waiting for word 3's acknowledge, with a late ack.
        rand_mem();
        ack_mode[3] = 3;
        go_menu();
        for (int i = 0; i < 4; i++) adr_q.push_back(8'(2 * i));
        acc0 = accepts;
        @(negedge clk);
        state_in = PLAY;
        n = 0;
        while (accepts < acc0 + 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reset_reach_word3", 112'(accepts - acc0), 112'(4));
        @(posedge clk);
        abandon = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        state_in = MENU;
        #2;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check_all_zero("late_ack");
        model_w = '0;
        clear_plan();

        // Fetch after reset recovery.
        rand_mem();
        run_fetch(1'b0, lat);
        chk("latency_post_reset", 112'(lat), 112'(14));

        // Randomised fetches.
        for (int k = 0; k < 12; k++) begin
            rand_mem();
            clear_plan();
            for (int i = 0; i < N; i++) stall_cnt[i] = int'($urandom_range(0, 3));
            fault = int'($urandom_range(0, 3));
            fw    = int'($urandom_range(0, N - 1));
            if (fault == 1) ack_mode[fw] = 1;
            if (fault == 2) ack_mode[fw] = 2;
            run_fetch(1'($urandom_range(0, 1)), lat);
            chk("latency_random", 112'(lat), 112'(exp_latency()));
        end
        clear_plan();

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 112'(exp_q.size()), 112'(0));
        chk("requests_drained", 112'(adr_q.size()), 112'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
